// File: rtl/pwm_pkg.sv
// Constants and types shared by the PWM generator and the PWM capture block.
package pwm_pkg;

  localparam int DIV_FAST_DEFAULT = 10416;
  localparam int DIV_SLOW_DEFAULT = 200000;
  localparam int FRAME_TICKS      = 128;
  localparam int TIMEOUT_TICKS    = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  function automatic logic [6:0] sat7(input logic [8:0] v);
    return (v > 9'd127) ? 7'd127 : v[6:0];
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM pin, plus registered
// single-cycle rise/fall pulses (three clocks from pin to pulse).
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // synchronizer chain and edge pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/tt_um_pwm_decoder.sv
// PWM capture: measures high time and period in prescaled ticks and reports
// the duty of each accepted 128-tick frame, with stuck-high/low detection.
module tt_um_pwm_decoder
  import pwm_pkg::*;
#(
  parameter int DIV_FAST = DIV_FAST_DEFAULT,
  parameter int DIV_SLOW = DIV_SLOW_DEFAULT,
  parameter int PER_TOL  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [17:0] DIV_F   = 18'(DIV_FAST);
  localparam logic [17:0] DIV_S   = 18'(DIV_SLOW);
  localparam logic [8:0]  P_MIN   = 9'(FRAME_TICKS - PER_TOL);
  localparam logic [8:0]  P_MAX   = 9'(FRAME_TICKS + PER_TOL);
  localparam logic [8:0]  T_LIMIT = 9'(TIMEOUT_TICKS);

  logic        rise;
  logic        fall;
  state_t      state;
  logic        sel;
  logic [17:0] q;
  logic [7:0]  h;
  logic [8:0]  p;
  logic [8:0]  t;
  logic [6:0]  h_lat;
  logic [6:0]  duty;
  logic        valid;
  logic        strobe;
  logic        stuck_hi;
  logic        stuck_lo;

  logic [17:0] div;
  logic        tick;
  logic [7:0]  h_eff;
  logic [8:0]  p_eff;
  logic [8:0]  t_eff;
  logic [17:0] q_eff;
  logic [8:0]  h_round;
  logic        timeout;
  logic        p_ok;
  logic        unused_ok;

  pwm_sync_edge u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ui_in[0]),
    .rise (rise),
    .fall (fall)
  );

  // this cycle's tick is folded in before any edge-driven clear
  always_comb begin
    div     = sel ? DIV_S : DIV_F;
    tick    = (q == div);
    h_eff   = (h == 8'd255) ? h : h + {7'd0, tick};
    p_eff   = (p == 9'd511) ? p : p + {8'd0, tick};
    t_eff   = t + {8'd0, tick};
    q_eff   = tick ? 18'd0 : q;
    h_round = {1'b0, h_eff} + {8'd0, (q_eff >= (div >> 1))};
    timeout = (t_eff == T_LIMIT) && !rise && !fall;
    p_ok    = (p_eff >= P_MIN) && (p_eff <= P_MAX);
  end

  // capture FSM with prescaler, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      q        <= 18'd0;
      h        <= 8'd0;
      p        <= 9'd0;
      t        <= 9'd0;
      h_lat    <= 7'd0;
      duty     <= 7'd0;
      valid    <= 1'b0;
      strobe   <= 1'b0;
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else if (!ena) begin
      state  <= IDLE;
      q      <= 18'd0;
      h      <= 8'd0;
      p      <= 9'd0;
      t      <= 9'd0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      case (state)
        IDLE: begin
          sel   <= ui_in[1];
          state <= WAIT_RISE;
        end
        default: begin
          q <= (rise || tick) ? 18'd0 : q + 18'd1;
          t <= (rise || fall || timeout) ? 9'd0 : t_eff;
          if (rise) begin
            sel <= ui_in[1];
          end
          if (timeout) begin
            state <= WAIT_RISE;
            q     <= 18'd0;
            h     <= 8'd0;
            p     <= 9'd0;
            valid <= 1'b0;
            if (state == HIGH) begin
              duty     <= 7'd127;
              stuck_hi <= 1'b1;
            end else begin
              duty     <= 7'd0;
              stuck_lo <= 1'b1;
            end
          end else begin
            case (state)
              WAIT_RISE: begin
                if (rise) begin
                  h     <= 8'd0;
                  p     <= 9'd0;
                  state <= HIGH;
                end
              end
              HIGH: begin
                h <= h_eff;
                p <= p_eff;
                if (fall) begin
                  h_lat <= sat7(h_round);
                  state <= LOW;
                end
              end
              LOW: begin
                p <= p_eff;
                if (rise) begin
                  if (p_ok) begin
                    duty     <= h_lat;
                    strobe   <= 1'b1;
                    valid    <= 1'b1;
                    stuck_hi <= 1'b0;
                    stuck_lo <= 1'b0;
                  end else begin
                    valid <= 1'b0;
                  end
                  h     <= 8'd0;
                  p     <= 9'd0;
                  state <= HIGH;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign uo_out    = {valid, duty};
  assign uio_out   = {5'd0, stuck_lo, stuck_hi, strobe};
  assign uio_oe    = 8'h07;
  assign unused_ok = &{1'b0, ui_in[7:2], uio_in};

endmodule
